// File: rtl/fe_tobytes_if.sv
// Handshake bus for the canonical-reduction stage.
// The slave side takes the operand in and drives the reduced result out.
interface fe_tobytes_if;
   localparam int unsigned W = 312;

   logic [W-1:0] f;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] h;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output f, in_valid, out_ready,
      input  in_ready, h, out_valid
   );

   modport slave (
      input  f, in_valid, out_ready,
      output in_ready, h, out_valid
   );
endinterface

// File: rtl/fe_tobytes.sv
// Reduces a 312-bit value mod p = 2^255-19 to its canonical form in [0, p-1].
// Two folds using 2^255 == 19, then one conditional subtract, so latency never depends on the data.
module fe_tobytes (
   input  logic        clk,
   input  logic        rst,
   fe_tobytes_if.slave bus
);
   localparam int unsigned W     = 312;
   localparam int unsigned SPLIT = 255;
   localparam int unsigned AW    = 257;
   localparam int unsigned HIW   = W - SPLIT;

   // p = 2^255 - 19: 250 ones above the low bits 5'b01101
   localparam logic [W-1:0]  P_MOD  = {57'd0, {250{1'b1}}, 5'b01101};
   localparam logic [AW-1:0] FOLD_K = AW'(19);

   typedef enum logic [2:0] {
      IDLE,
      FOLD1,
      FOLD2,
      SUB,
      DONE
   } state_e;

   state_e       state_q, state_d;
   logic [W-1:0] x_q, x_d;
   logic         in_ready_q;
   logic         out_valid_q;

   logic [AW-1:0] fold1_sum;
   logic [AW-1:0] fold2_sum;
   logic          x_ge_p;

   // First fold brings the value below 2^256, the second below 2^255 + 19
   assign fold1_sum = AW'(x_q[SPLIT-1:0]) + AW'(x_q[W-1:SPLIT]) * FOLD_K;
   assign fold2_sum = AW'(x_q[SPLIT-1:0]) + (x_q[SPLIT] ? FOLD_K : '0);
   assign x_ge_p    = (x_q >= P_MOD);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               x_d     = bus.f;
               state_d = FOLD1;
            end
         end
         FOLD1: begin
            x_d     = W'(fold1_sum);
            state_d = FOLD2;
         end
         FOLD2: begin
            x_d     = W'(fold2_sum);
            state_d = SUB;
         end
         SUB: begin
            if (x_ge_p) begin
               x_d = x_q - P_MOD;
            end
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake flags are registered copies of the next-state decode
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.h         = {HIW'(0), x_q[SPLIT-1:0]};
endmodule

// File: tb/tb_fe_tobytes.sv
// Directed and randomised checks of fe_tobytes against hand-computed values and f mod p.
`timescale 1ns/1ps
module tb_fe_tobytes;
   localparam logic [311:0] P  = {57'd0, {250{1'b1}}, 5'b01101};
   localparam logic [311:0] P2 = {56'd0, {250{1'b1}}, 6'b011010};
   localparam logic [311:0] M256 = {56'd0, {256{1'b1}}};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   fe_tobytes_if bus ();

   fe_tobytes dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // Presents one operand from IDLE and waits for out_valid; no checks here.
   task automatic send_and_wait(input logic [311:0] fv, input logic ordy,
                                output logic [311:0] hv, output int lat, output bit ok);
      @(negedge clk);
      bus.f         = fv;
      bus.in_valid  = 1'b1;
      bus.out_ready = ordy;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      hv = bus.h;
   endtask

   task automatic test_reset();
      int seen;
      bus.f         = '1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      n_checks++;
      if (bus.h !== 312'd0) begin
         n_fail++; $display("FAIL reset_h: got %h want 0", bus.h);
      end
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++; $display("FAIL reset_in_valid_ignored: got %0d non-idle cycles want 0", seen);
      end
   endtask

   task automatic test_boundaries();
      logic [311:0] vf [9];
      logic [311:0] ve [9];
      logic [311:0] hv;
      logic [311:0] t;
      int lat;
      bit ok;
      t = '0; t[255] = 1'b1;
      vf[0] = 312'h13;  ve[0] = 312'h13;
      vf[1] = P;        ve[1] = 312'd0;
      vf[2] = P - 1;    ve[2] = P - 1;
      vf[3] = t;        ve[3] = 312'h13;
      vf[4] = P2;       ve[4] = 312'd0;
      vf[5] = '1;       ve[5] = 312'h25FFFFFFFFFFFFFF;
      vf[6] = 312'd0;   ve[6] = 312'd0;
      vf[7] = M256;     ve[7] = 312'd37;
      vf[8] = P + 18;   ve[8] = 312'd18;
      for (int i = 0; i < 9; i++) begin
         send_and_wait(vf[i], 1'b1, hv, lat, ok);
         n_checks++;
         if (!ok) begin
            n_fail++; $display("FAIL vec%0d_timeout: out_valid never rose", i);
         end
         n_checks++;
         if (lat != 3) begin
            n_fail++; $display("FAIL vec%0d_latency: got %0d want 3", i, lat);
         end
         n_checks++;
         if (hv !== ve[i]) begin
            n_fail++; $display("FAIL vec%0d_h: got %h want %h", i, hv, ve[i]);
         end
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL vec%0d_release: out_valid=%b in_ready=%b want 0/1",
                               i, bus.out_valid, bus.in_ready);
         end
      end
   endtask

   task automatic test_stall();
      logic [311:0] hv;
      logic [311:0] want;
      int lat, bad, seen;
      bit ok;
      want = 312'h25FFFFFFFFFFFFFF;
      send_and_wait('1, 1'b0, hv, lat, ok);
      n_checks++;
      if (!ok || hv !== want) begin
         n_fail++; $display("FAIL stall_h: ok=%0d got %h want %h", ok, hv, want);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = i[0];
         bus.f        = 312'h13;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.h !== want) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_release: out_valid=%b in_ready=%b want 0/1",
                            bus.out_valid, bus.in_ready);
      end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++; $display("FAIL stall_no_queue: got %0d valid cycles want 0", seen);
      end
   endtask

   task automatic test_reset_mid();
      logic [311:0] hv;
      int lat, seen;
      bit ok;
      @(negedge clk);
      bus.f         = P - 1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.h !== 312'd0) begin
         n_fail++; $display("FAIL rst_fold2: in_ready=%b out_valid=%b h=%h want 1/0/0",
                            bus.in_ready, bus.out_valid, bus.h);
      end
      rst  = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++; $display("FAIL rst_fold2_discard: got %0d valid cycles want 0", seen);
      end
      send_and_wait(312'h13, 1'b0, hv, lat, ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL rst_done_setup: out_valid never rose");
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.h !== 312'd0) begin
         n_fail++; $display("FAIL rst_done: in_ready=%b out_valid=%b h=%h want 1/0/0",
                            bus.in_ready, bus.out_valid, bus.h);
      end
   endtask

   task automatic test_throughput();
      int stamps [3];
      int n;
      n = 0;
      @(negedge clk);
      bus.f         = 312'h13;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1 && n < 3) begin
            stamps[n] = c;
            n++;
         end
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (n != 3) begin
         n_fail++; $display("FAIL tput_count: got %0d results want 3", n);
      end else begin
         n_checks++;
         if (stamps[1] - stamps[0] != 5 || stamps[2] - stamps[1] != 5) begin
            n_fail++; $display("FAIL tput_period: got %0d,%0d want 5,5",
                               stamps[1] - stamps[0], stamps[2] - stamps[1]);
         end
      end
      for (int c = 0; c < 10 && bus.in_ready !== 1'b1; c++) @(negedge clk);
   endtask

   function automatic logic [311:0] rand_f();
      logic [311:0] t;
      t = '0;
      for (int k = 0; k < 10; k++) t = {t[279:0], 32'($urandom())};
      case ($urandom_range(0, 4))
         1: t = t & M256;
         2: t = P + 312'($urandom_range(0, 40));
         3: t = P2 + 312'($urandom_range(0, 40));
         4: t = 312'($urandom_range(0, 100));
         default: ;
      endcase
      return t;
   endfunction

   task automatic test_back_to_back();
      logic [311:0] fv;
      logic [311:0] want;
      bit done;
      for (int n = 0; n < 10000; n++) begin
         fv   = rand_f();
         want = fv % P;
         @(negedge clk);
         n_checks++;
         if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rnd%0d_in_ready: got %b want 1", n, bus.in_ready);
         end
         bus.f        = fv;
         bus.in_valid = 1'b1;
         done = 1'b0;
         for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
               done = 1'b1;
               n_checks++;
               if (bus.h !== want || bus.h[311:255] !== 57'd0) begin
                  n_fail++; $display("FAIL rnd%0d_h: f=%h got %h want %h", n, fv, bus.h, want);
               end
            end
         end
         if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL rnd%0d_timeout: no result within 200 cycles", n);
         end
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.f         = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_boundaries();
      test_stall();
      test_reset_mid();
      test_throughput();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
